lifo_reader: RTL and testbench
==============================

# lifo_reader

Synchronous consumer for the 6-entry result/opcode LIFO of the lab 2 calculator datapath. It converts single-cycle pop and drain requests into clean, well-spaced read pulses on the LIFO's edge-triggered `read` input, then captures the popped result/opcode pair into display registers. It also holds off the LIFO writer while a pop is in flight. It sits between the button debouncers and the LIFO, and feeds the seven-segment display path.

## Interface
- `PULSE_W`, default 2: number of clock cycles `lifo_read` stays high per pop (≥1).
- `SETTLE`, default 1: number of cycles after `lifo_read` falls before the LIFO outputs are sampled (≥1).
- `DWELL`, default 25_000_000: cycles each entry is held on the display between pops in drain mode (≥1).
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `pop_req`, input, 1: single-cycle pulse; pop one entry.
- `drain_req`, input, 1: single-cycle pulse; pop entries until the LIFO is empty.
- `lifo_empty`, input, 1: `empty` flag from the LIFO.
- `lifo_result`, input, 6: `result` output of the LIFO.
- `lifo_opcode`, input, 3: `opcodeselout` output of the LIFO.
- `lifo_read`, output, 1: read strobe to the LIFO. Registered, glitch-free.
- `wr_inhibit`, output, 1: high whenever state ≠ IDLE; the writer must not pulse `write` while it is high.
- `disp_result`, output, 6: last captured result.
- `disp_opcode`, output, 3: last captured opcode.
- `disp_valid`, output, 1: set on first capture; stays high until reset.
- `pop_count`, output, 3: entries popped since reset, saturating at 7.
- `done`, output, 1: one-cycle pulse when a single pop or a whole drain completes.
- `underflow`, output, 1: one-cycle pulse when a request arrives while `lifo_empty`=1.

## Operation
- **States:** IDLE, PULSE, SETTLE, CAPTURE, DWELL. The `drain` mode bit is latched on entry from IDLE.
- **IDLE, request handling:**
  - `drain_req`=1 has priority over `pop_req`. If both are high, treat the request as a drain.
  - Request with `lifo_empty`=1: pulse `underflow`, stay in IDLE, no read pulse, display unchanged.
  - Request with `lifo_empty`=0: go to PULSE, set `lifo_read`=1, load the counter with PULSE_W.
- **PULSE:** keep `lifo_read`=1 until the counter expires. Then set `lifo_read`=0 and go to SETTLE with the counter loaded to SETTLE.
- **SETTLE:** wait for the counter, then go to CAPTURE.
- **CAPTURE (one cycle):** register `lifo_result`/`lifo_opcode` into the display outputs, set `disp_valid`, and increment `pop_count` (saturating).
  - Single-pop mode: pulse `done`, return to IDLE.
  - Drain mode: go to DWELL with the counter loaded to DWELL.
- **DWELL:** when the counter expires, check `lifo_empty`. If 1: pulse `done` and return to IDLE. If 0: go to PULSE.
- **Requests outside IDLE** (including a `drain_req` during a single pop) are ignored and not queued.
- `lifo_read` and `write` never overlap, provided the writer honours `wr_inhibit`.
- The counter is wide enough for max(PULSE_W, SETTLE, DWELL). All outputs are registered.

## Timing
- **Reset:** while `reset_n`=0, all outputs are forced low or zero immediately. `lifo_read`=0, `wr_inhibit`=0, `disp_*`=0, `disp_valid`=0, `pop_count`=0, `done`=0, `underflow`=0, state=IDLE.
- **Reset mid-pulse:** an asserted `lifo_read` drops asynchronously. The partially completed pop is not captured and not counted.
- **Single-pop sequence**, with the request sampled at edge E0:
  - `lifo_read` is high after E0 through edge E0+PULSE_W.
  - Data is captured and `done` goes high after edge E0+PULSE_W+SETTLE+1.
  - Defaults: read high for 2 cycles, capture 4 cycles after the request.
- **`wr_inhibit`** is high from after E0 until IDLE is re-entered.
- **Drain spacing:** consecutive rising edges of `lifo_read` are PULSE_W+SETTLE+1+DWELL cycles apart.
- **Underflow:** `underflow` is high for the single cycle after the sampling edge.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-PULSE → `lifo_read` falls within the same cycle; all outputs 0; `pop_count`=0.
- **Single pop:** LIFO model holds (0x2A, op 3). `pop_req` at E0 → `lifo_read` high exactly 2 cycles; `disp_result`=0x2A, `disp_opcode`=3, `pop_count`=1, `done` pulse at E0+4.
- **Underflow:** empty LIFO, `pop_req` → `underflow` pulse for 1 cycle, `lifo_read` never rises, `disp_valid` stays 0.
- **Drain (DWELL=4):** LIFO loaded with 0x01, 0x02, 0x03 (0x03 on top), `drain_req` → captures 0x03, 0x02, 0x01 in order with rising edges of `lifo_read` 8 cycles apart, `pop_count`=3, a single `done` after the last dwell.
- **Priority and ignore rules:**
  - `pop_req` and `drain_req` in the same cycle → drain behaviour.
  - A second `pop_req` during PULSE/SETTLE → ignored; exactly one read pulse.
- **Saturation and interlock:** perform 8 pops with refills in between → `pop_count` saturates at 7. `wr_inhibit` is high in every cycle `lifo_read` is high.

Source files
------------

// File: rtl/lifo_reader.sv
// Pops the calculator's result/opcode LIFO with spaced read strobes and latches
// the popped pair for the seven-segment display; drain mode walks the whole stack.
module lifo_reader #(
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 1,
  parameter int DWELL   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pop_req,
  input  logic       drain_req,
  input  logic       lifo_empty,
  input  logic [5:0] lifo_result,
  input  logic [2:0] lifo_opcode,
  output logic       lifo_read,
  output logic       wr_inhibit,
  output logic [5:0] disp_result,
  output logic [2:0] disp_opcode,
  output logic       disp_valid,
  output logic [2:0] pop_count,
  output logic       done,
  output logic       underflow
);

  localparam int MAXC = (PULSE_W > SETTLE) ? ((PULSE_W > DWELL) ? PULSE_W : DWELL)
                                           : ((SETTLE  > DWELL) ? SETTLE  : DWELL);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_PULSE  = CW'(PULSE_W);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE);
  localparam logic [CW-1:0] LD_DWELL  = CW'(DWELL);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DWELL   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          drain;

  // Counter holds the cycles remaining in the current phase; a value of one
  // marks the last cycle, so each phase lasts exactly its loaded count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      drain       <= 1'b0;
      lifo_read   <= 1'b0;
      wr_inhibit  <= 1'b0;
      disp_result <= '0;
      disp_opcode <= '0;
      disp_valid  <= 1'b0;
      pop_count   <= '0;
      done        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      done      <= 1'b0;
      underflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_req || drain_req) begin
            if (lifo_empty) begin
              underflow <= 1'b1;
            end else begin
              drain      <= drain_req;
              state      <= ST_PULSE;
              lifo_read  <= 1'b1;
              wr_inhibit <= 1'b1;
              cnt        <= LD_PULSE;
            end
          end
        end
        ST_PULSE: begin
          if (cnt == ONE) begin
            lifo_read <= 1'b0;
            state     <= ST_SETTLE;
            cnt       <= LD_SETTLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt == ONE) state <= ST_CAPTURE;
          else            cnt   <= cnt - ONE;
        end
        ST_CAPTURE: begin
          disp_result <= lifo_result;
          disp_opcode <= lifo_opcode;
          disp_valid  <= 1'b1;
          if (pop_count != 3'd7) pop_count <= pop_count + 3'd1;
          if (drain) begin
            state <= ST_DWELL;
            cnt   <= LD_DWELL;
          end else begin
            done       <= 1'b1;
            state      <= ST_IDLE;
            wr_inhibit <= 1'b0;
          end
        end
        ST_DWELL: begin
          if (cnt == ONE) begin
            if (lifo_empty) begin
              done       <= 1'b1;
              state      <= ST_IDLE;
              wr_inhibit <= 1'b0;
            end else begin
              state     <= ST_PULSE;
              lifo_read <= 1'b1;
              cnt       <= LD_PULSE;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          lifo_read  <= 1'b0;
          wr_inhibit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_reader.sv
// Directed bench for lifo_reader: a behavioural stack pops on each rising edge
// of lifo_read; a negedge monitor counts strobes, pulses and interlock breaks.
module tb_lifo_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pop_req = 1'b0, drain_req = 1'b0;
  logic       lifo_empty;
  logic [5:0] lifo_result = '0;
  logic [2:0] lifo_opcode = '0;
  logic       lifo_read, wr_inhibit, disp_valid, done, underflow;
  logic [5:0] disp_result;
  logic [2:0] disp_opcode, pop_count;

  lifo_reader #(.PULSE_W(2), .SETTLE(1), .DWELL(4)) dut (
    .clk(clk), .reset_n(reset_n), .pop_req(pop_req), .drain_req(drain_req),
    .lifo_empty(lifo_empty), .lifo_result(lifo_result), .lifo_opcode(lifo_opcode),
    .lifo_read(lifo_read), .wr_inhibit(wr_inhibit), .disp_result(disp_result),
    .disp_opcode(disp_opcode), .disp_valid(disp_valid), .pop_count(pop_count),
    .done(done), .underflow(underflow));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // stack model
  logic [5:0] s_res [0:7];
  logic [2:0] s_op  [0:7];
  int sp = 0;
  assign lifo_empty = (sp == 0);
  always @(posedge lifo_read) begin
    if (sp > 0) begin
      sp = sp - 1;
      lifo_result = s_res[sp];
      lifo_opcode = s_op[sp];
    end
  end

  task automatic push(input logic [5:0] r, input logic [2:0] o);
    s_res[sp] = r; s_op[sp] = o; sp = sp + 1;
  endtask

  // monitor
  int nr, read_hi, done_n, uf_n, viol, done_cyc;
  int rise [0:15];
  logic prev_read = 1'b0;
  always @(negedge clk) begin
    if (lifo_read && !prev_read && nr < 16) begin rise[nr] = cyc; nr++; end
    prev_read = lifo_read;
    if (lifo_read) read_hi++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (underflow) uf_n++;
    if (lifo_read && !wr_inhibit) viol++;
  end

  task automatic clr_mon();
    nr = 0; read_hi = 0; done_n = 0; uf_n = 0; viol = 0; done_cyc = -1;
  endtask

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic req(input logic p, input logic d);
    @(negedge clk); #1;
    pop_req = p; drain_req = d;
    @(negedge clk); #1;
    pop_req = 1'b0; drain_req = 1'b0;
  endtask

  typedef struct {
    bit              pop;
    bit              drain;
    int              n;
    logic [2:0][5:0] r;
    logic [2:0][2:0] o;
    int              reads;
    logic [5:0]      res;
    logic [2:0]      op;
    logic            vld;
    logic [2:0]      cnt;
    int              dn;
    int              uf;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // pop/drain,n,  entries (index 0 = bottom),          reads,res,op,vld,cnt,done,uf
    tbl[0] = '{1'b1, 1'b0, 0, 18'h0, 9'h0,                       0, 6'h00, 3'd0, 1'b0, 3'd0, 0, 1};
    tbl[1] = '{1'b1, 1'b0, 1, {6'h0, 6'h0, 6'h2A}, {3'd0, 3'd0, 3'd3}, 1, 6'h2A, 3'd3, 1'b1, 3'd1, 1, 0};
    tbl[2] = '{1'b0, 1'b1, 3, {6'h03, 6'h02, 6'h01}, {3'd3, 3'd2, 3'd1}, 3, 6'h01, 3'd1, 1'b1, 3'd4, 1, 0};
    tbl[3] = '{1'b1, 1'b1, 2, {6'h0, 6'h11, 6'h10}, {3'd0, 3'd6, 3'd5}, 2, 6'h10, 3'd5, 1'b1, 3'd6, 1, 0};
    tbl[4] = '{1'b0, 1'b1, 0, 18'h0, 9'h0,                       0, 6'h10, 3'd5, 1'b1, 3'd6, 0, 1};
    tbl[5] = '{1'b1, 1'b0, 2, {6'h0, 6'h05, 6'h3F}, {3'd0, 3'd2, 3'd7}, 1, 6'h05, 3'd2, 1'b1, 3'd7, 1, 0};
    tbl[6] = '{1'b1, 1'b0, 1, {6'h0, 6'h0, 6'h00}, {3'd0, 3'd0, 3'd0}, 1, 6'h00, 3'd0, 1'b1, 3'd7, 1, 0};

    clr_mon();
    #1;
    chk("rst read", lifo_read, 0);
    chk("rst inhibit", wr_inhibit, 0);
    chk("rst valid", disp_valid, 0);
    chk("rst count", pop_count, 0);
    chk("rst disp", {disp_result, disp_opcode}, 0);
    chk("rst pulses", {done, underflow}, 0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // table of whole transactions, results accumulate across rows
    for (int i = 0; i < 7; i++) begin
      clr_mon();
      sp = 0;
      for (int j = 0; j < tbl[i].n; j++) push(tbl[i].r[j], tbl[i].o[j]);
      req(tbl[i].pop, tbl[i].drain);
      repeat (60) @(negedge clk);
      chk($sformatf("v%0d reads", i), nr, tbl[i].reads);
      chk($sformatf("v%0d read_hi", i), read_hi, 2 * tbl[i].reads);
      chk($sformatf("v%0d result", i), disp_result, tbl[i].res);
      chk($sformatf("v%0d opcode", i), disp_opcode, tbl[i].op);
      chk($sformatf("v%0d valid", i), disp_valid, tbl[i].vld);
      chk($sformatf("v%0d count", i), pop_count, tbl[i].cnt);
      chk($sformatf("v%0d done", i), done_n, tbl[i].dn);
      chk($sformatf("v%0d underflow", i), uf_n, tbl[i].uf);
      chk($sformatf("v%0d interlock", i), viol, 0);
      chk($sformatf("v%0d idle inhibit", i), wr_inhibit, 0);
      for (int k = 0; k + 1 < tbl[i].reads; k++)
        chk($sformatf("v%0d spacing%0d", i, k), rise[k+1] - rise[k], 8);
    end

    // single-pop latency: read high after E0, done observed after E0+4
    begin
      int c0;
      clr_mon();
      sp = 0; push(6'h2A, 3'd3);
      @(negedge clk); #1;
      c0 = cyc + 1;
      pop_req = 1'b1;
      @(negedge clk); #1 pop_req = 1'b0;
      chk("lat inhibit", wr_inhibit, 1);
      repeat (12) @(negedge clk);
      chk("lat rise", rise[0], c0);
      chk("lat read_hi", read_hi, 2);
      chk("lat done", done_cyc, c0 + 4);
      chk("lat done_n", done_n, 1);
    end

    // reset during PULSE drops the strobe at once and discards the pop
    clr_mon();
    sp = 0; push(6'h15, 3'd1);
    @(negedge clk); #1 pop_req = 1'b1;
    @(posedge clk); #2 pop_req = 1'b0;
    chk("mid read before", lifo_read, 1);
    reset_n = 1'b0;
    #1;
    chk("mid read", lifo_read, 0);
    chk("mid inhibit", wr_inhibit, 0);
    chk("mid count", pop_count, 0);
    chk("mid disp", {disp_valid, disp_result, disp_opcode}, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid after count", pop_count, 0);
    chk("mid after valid", disp_valid, 0);

    // requests while busy are dropped
    clr_mon();
    sp = 0; push(6'h21, 3'd1); push(6'h22, 3'd2); push(6'h23, 3'd3);
    @(negedge clk); #1 pop_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      pop_req = (k == 0); drain_req = (k > 0);
    end
    @(negedge clk); #1 pop_req = 1'b0; drain_req = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy reads", nr, 1);
    chk("busy result", disp_result, 6'h23);
    chk("busy opcode", disp_opcode, 3'd3);
    chk("busy left", sp, 2);
    chk("busy count", pop_count, 1);
    chk("busy done", done_n, 1);

    // saturation over eight refilled pops (count starts at 1 from above)
    for (int i = 0; i < 8; i++) begin
      sp = 0; push(6'(i * 3 + 1), 3'(i));
      req(1'b1, 1'b0);
      repeat (10) @(negedge clk);
      chk($sformatf("sat%0d count", i), pop_count, (i + 2 > 7) ? 7 : i + 2);
      chk($sformatf("sat%0d result", i), disp_result, 6'(i * 3 + 1));
    end
    chk("sat interlock", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
